bp_table_scheduler: RTL and testbench

Sequences all accesses to the branch predictor's single-port weight table. Two requesters share the port: decode-stage prediction reads and execute-stage training read-modify-writes. The block queues execute feedback in a small FIFO, owns the global history register (GHR), computes table indices, and drives the table opcode to the weight datapath. Predictions take priority over training, and a starvation counter bounds how long training can be deferred.

---
 rtl/bp_table_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_bp_table_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_table_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bp_table_scheduler
// Purpose  : Arbitrates the branch predictor's single-port weight table
//            between decode-stage prediction reads and execute-stage training
//            read-modify-writes. Queues execute feedback in a small FIFO, owns
//            the global history register (GHR), computes table indices and
//            drives the table opcode. Predictions have priority; a starvation
//            counter forces training through after STARVE_LIMIT deferrals.
// Ports    : clk, rst_n (sync, active-low)
//            i_req_*  / o_req_*  : decode prediction request, stall, GHR
//            i_fb_*   / o_fb_*   : execute feedback and back-pressure
//            o_tbl_op, o_tbl_idx : table opcode / row (0 NONE, 1 PRED_READ,
//                                  2 TRAIN_READ, 3 TRAIN_WRITE)
//            o_trn_*, i_trn_update : training entry and datapath verdict
//            o_drop_cnt          : dropped-feedback count (drop mode only)
//            o_busy              : FSM active or FIFO non-empty
// Config   : BP_SCHED_DROP_EN - never back-pressure; discard feedback when
//            the FIFO is full (GHR still shifts) and count discards.
// Revision : 1.0 - initial release
// ============================================================================
module bp_table_scheduler #(
   parameter int ADDR_WIDTH   = 32,
   parameter int IDX_BITS     = 8,
   parameter int HIST_BITS    = 7,   // 2 .. IDX_BITS
   parameter int FIFO_DEPTH   = 4,   // power of two, >= 2
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_pc,
   output logic                  o_req_stall,
   output logic [HIST_BITS-1:0]  o_req_hist,
   input  logic                  i_fb_valid,
   input  logic [ADDR_WIDTH-1:0] i_fb_pc,
   input  logic [HIST_BITS-1:0]  i_fb_hist,
   input  logic                  i_fb_outcome,
   input  logic                  i_fb_mispredict,
   output logic                  o_fb_stall,
   output logic [1:0]            o_tbl_op,
   output logic [IDX_BITS-1:0]   o_tbl_idx,
   output logic [HIST_BITS-1:0]  o_trn_hist,
   output logic                  o_trn_outcome,
   output logic                  o_trn_mispredict,
   input  logic                  i_trn_update,
`ifdef BP_SCHED_DROP_EN
   output logic [15:0]           o_drop_cnt,
`endif
   output logic                  o_busy
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
   localparam logic [c_STV_W-1:0] c_STV_MAX  = c_STV_W'(STARVE_LIMIT);
   localparam logic [c_STV_W-1:0] c_STV_ONE  = c_STV_W'(1);

   localparam logic [1:0] c_OP_NONE = 2'd0;
   localparam logic [1:0] c_OP_PRED = 2'd1;
   localparam logic [1:0] c_OP_TRD  = 2'd2;
   localparam logic [1:0] c_OP_TWR  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_EVAL = 2'd2,
      S_WR   = 2'd3
   } state_t;

   typedef struct packed {
      logic [IDX_BITS-1:0]  idx;
      logic [HIST_BITS-1:0] hist;
      logic                 outcome;
      logic                 mispredict;
   } entry_t;

   state_t               state_q;
   entry_t               trn_q;
   logic [HIST_BITS-1:0] ghr_q, ghr_d;
   logic [c_STV_W-1:0]   starve_q;
   logic [c_CNT_W-1:0]   cnt_q, cnt_d;
   logic [c_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   entry_t               fifo_mem [0:FIFO_DEPTH-1];

   logic                 w_full, w_fb_push, w_pop, w_ghr_shift;
   logic                 w_trn_phase, w_pred_wins, w_trn_grant;
   logic [IDX_BITS-1:0]  w_req_idx, w_fb_idx;
   entry_t               w_fb_entry;
   logic                 w_unused_pc_bits;

   // Only the word-aligned index bits of the PCs feed the table.
   assign w_unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:IDX_BITS+2], i_req_pc[1:0],
                               i_fb_pc[ADDR_WIDTH-1:IDX_BITS+2], i_fb_pc[1:0]};

   assign w_req_idx  = i_req_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
   assign w_fb_idx   = i_fb_pc[IDX_BITS+1:2] ^ IDX_BITS'(i_fb_hist);
   assign w_fb_entry = {w_fb_idx, i_fb_hist, i_fb_outcome, i_fb_mispredict};

   // Full is judged on the registered count: a pop in the same cycle does
   // not make room for a push.
   assign w_full    = (cnt_q == c_CNT_FULL);
   assign w_fb_push = i_fb_valid && !w_full;
   assign w_pop     = (state_q == S_IDLE) && (cnt_q != '0);

`ifdef BP_SCHED_DROP_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else if (i_fb_valid && w_full && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign o_drop_cnt  = drop_cnt_q;
   assign o_fb_stall  = 1'b0;
   // History tracks every resolved branch, even if its training is lost.
   assign w_ghr_shift = i_fb_valid;
`else
   assign o_fb_stall  = w_full;
   assign w_ghr_shift = w_fb_push;
`endif

   // Port arbitration only matters while training wants the table.
   assign w_trn_phase = (state_q == S_RD) || (state_q == S_WR);
   assign w_pred_wins = i_req_valid && (starve_q < c_STV_MAX);
   assign w_trn_grant = w_trn_phase && !w_pred_wins;

   always_comb begin
      o_tbl_op  = c_OP_NONE;
      o_tbl_idx = '0;
      if (w_trn_grant) begin
         o_tbl_op  = (state_q == S_RD) ? c_OP_TRD : c_OP_TWR;
         o_tbl_idx = trn_q.idx;
      end else if (i_req_valid) begin
         o_tbl_op  = c_OP_PRED;
         o_tbl_idx = w_req_idx;
      end
   end

   assign o_req_stall      = w_trn_phase && (starve_q == c_STV_MAX);
   assign o_req_hist       = ghr_q;
   assign o_trn_hist       = trn_q.hist;
   assign o_trn_outcome    = trn_q.outcome;
   assign o_trn_mispredict = trn_q.mispredict;
   assign o_busy           = (state_q != S_IDLE) || (cnt_q != '0);

   always_comb begin
      cnt_d = cnt_q;
      if (w_fb_push && !w_pop) begin
         cnt_d = cnt_q + c_CNT_ONE;
      end else if (!w_fb_push && w_pop) begin
         cnt_d = cnt_q - c_CNT_ONE;
      end
   end

   always_comb begin
      ghr_d = ghr_q;
      if (w_ghr_shift) begin
         ghr_d = {ghr_q[HIST_BITS-2:0], i_fb_outcome};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ghr_q    <= '0;
      end else begin
         cnt_q <= cnt_d;
         ghr_q <= ghr_d;
         if (w_fb_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
         if (w_pop)     rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      end
   end

   // Storage is not reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (rst_n && w_fb_push) begin
         fifo_mem[wr_ptr_q] <= w_fb_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         trn_q    <= '0;
         starve_q <= '0;
      end else begin
         if (w_trn_grant) begin
            starve_q <= '0;
         end else if (w_trn_phase && i_req_valid) begin
            starve_q <= starve_q + c_STV_ONE;
         end

         case (state_q)
            S_IDLE: begin
               if (w_pop) begin
                  trn_q   <= fifo_mem[rd_ptr_q];
                  state_q <= S_RD;
               end
            end
            S_RD:    if (w_trn_grant) state_q <= S_EVAL;
            S_EVAL:  state_q <= i_trn_update ? S_WR : S_IDLE;
            S_WR:    if (w_trn_grant) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bp_table_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_table_scheduler
// Purpose  : Directed scoreboard bench for bp_table_scheduler. Stimulus pushes
//            the expected table operation of each cycle into a queue; a
//            monitor pops and compares whenever the DUT drives a table op.
//            Status outputs are checked directly from the stimulus thread.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bp_table_scheduler;

   localparam int AW = 32;
   localparam int IW = 8;
   localparam int HW = 7;

   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_PRED = 2'd1;
   localparam logic [1:0] OP_TRD  = 2'd2;
   localparam logic [1:0] OP_TWR  = 2'd3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_req_valid;
   logic [AW-1:0] i_req_pc;
   logic          o_req_stall;
   logic [HW-1:0] o_req_hist;
   logic          i_fb_valid;
   logic [AW-1:0] i_fb_pc;
   logic [HW-1:0] i_fb_hist;
   logic          i_fb_outcome;
   logic          i_fb_mispredict;
   logic          o_fb_stall;
   logic [1:0]    o_tbl_op;
   logic [IW-1:0] o_tbl_idx;
   logic [HW-1:0] o_trn_hist;
   logic          o_trn_outcome;
   logic          o_trn_mispredict;
   logic          i_trn_update;
   logic          o_busy;
`ifdef BP_SCHED_DROP_EN
   logic [15:0]   o_drop_cnt;
`endif

   bp_table_scheduler dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_req_valid      (i_req_valid),
      .i_req_pc         (i_req_pc),
      .o_req_stall      (o_req_stall),
      .o_req_hist       (o_req_hist),
      .i_fb_valid       (i_fb_valid),
      .i_fb_pc          (i_fb_pc),
      .i_fb_hist        (i_fb_hist),
      .i_fb_outcome     (i_fb_outcome),
      .i_fb_mispredict  (i_fb_mispredict),
      .o_fb_stall       (o_fb_stall),
      .o_tbl_op         (o_tbl_op),
      .o_tbl_idx        (o_tbl_idx),
      .o_trn_hist       (o_trn_hist),
      .o_trn_outcome    (o_trn_outcome),
      .o_trn_mispredict (o_trn_mispredict),
      .i_trn_update     (i_trn_update),
`ifdef BP_SCHED_DROP_EN
      .o_drop_cnt       (o_drop_cnt),
`endif
      .o_busy           (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]    op;
      logic [IW-1:0] idx;
      logic          stall;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors     = 0;
   int   miscompares = 0;
   bit   mon_en      = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor: every non-NONE table op must match the next expectation.
   always @(negedge clk) begin
      if (mon_en && (o_tbl_op != OP_NONE)) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_op: got op %0d idx 0x%0h, expected no op (t=%0t)",
                     o_tbl_op, o_tbl_idx, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("tbl_op",    {30'd0, o_tbl_op}, {30'd0, mon_e.op});
            check("tbl_idx",   {24'd0, o_tbl_idx}, {24'd0, mon_e.idx});
            check("req_stall", {31'd0, o_req_stall}, {31'd0, mon_e.stall});
         end
      end
   end

   task automatic expect_op(input logic [1:0] op, input logic [IW-1:0] idx, input logic stall);
      exp_t e;
      e.op    = op;
      e.idx   = idx;
      e.stall = stall;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle_in();
      i_req_valid     = 1'b0;
      i_req_pc        = '0;
      i_fb_valid      = 1'b0;
      i_fb_pc         = '0;
      i_fb_hist       = '0;
      i_fb_outcome    = 1'b0;
      i_fb_mispredict = 1'b0;
      i_trn_update    = 1'b0;
   endtask

   task automatic req(input logic [AW-1:0] pc);
      i_req_valid = 1'b1;
      i_req_pc    = pc;
   endtask

   task automatic fb(input logic [AW-1:0] pc, input logic [HW-1:0] h, input logic o, input logic m);
      i_fb_valid      = 1'b1;
      i_fb_pc         = pc;
      i_fb_hist       = h;
      i_fb_outcome    = o;
      i_fb_mispredict = m;
   endtask

   logic [HW-1:0] g7;
   logic [HW-1:0] g9;
   logic          fs_full;

   initial begin
`ifdef BP_SCHED_DROP_EN
      g7      = 7'h21;
      g9      = 7'h42;
      fs_full = 1'b0;
`else
      g7      = 7'h50;
      g9      = 7'h50;
      fs_full = 1'b1;
`endif
      idle_in();
      rst_n = 1'b0;
      cyc();
      cyc();
      settle();
      check("rst_tbl_op",   {30'd0, o_tbl_op}, 32'd0);
      check("rst_tbl_idx",  {24'd0, o_tbl_idx}, 32'd0);
      check("rst_req_stall",{31'd0, o_req_stall}, 32'd0);
      check("rst_fb_stall", {31'd0, o_fb_stall}, 32'd0);
      check("rst_req_hist", {25'd0, o_req_hist}, 32'd0);
      check("rst_trn",      {23'd0, o_trn_hist, o_trn_outcome, o_trn_mispredict}, 32'd0);
      check("rst_busy",     {31'd0, o_busy}, 32'd0);

      // Idle prediction.
      cyc(); rst_n = 1'b1; mon_en = 1'b1;
      req(32'h40); expect_op(OP_PRED, 8'h10, 1'b0); settle();
      check("idle_req_hist", {25'd0, o_req_hist}, 32'd0);
      check("idle_busy",     {31'd0, o_busy}, 32'd0);
`ifdef BP_SCHED_DROP_EN
      check("idle_drop_cnt", {16'd0, o_drop_cnt}, 32'd0);
`endif

      // Training without contention.
      cyc(); idle_in(); fb(32'h44, 7'h03, 1'b1, 1'b1); settle();
      check("t0_fb_stall", {31'd0, o_fb_stall}, 32'd0);
      check("t0_busy",     {31'd0, o_busy}, 32'd0);
      cyc(); idle_in(); settle();
      check("t1_ghr",  {25'd0, o_req_hist}, 32'h01);
      check("t1_busy", {31'd0, o_busy}, 32'd1);
      cyc(); idle_in(); expect_op(OP_TRD, 8'h12, 1'b0); settle();
      check("t2_trn_hist", {25'd0, o_trn_hist}, 32'h03);
      check("t2_trn_out",  {31'd0, o_trn_outcome}, 32'd1);
      check("t2_trn_mis",  {31'd0, o_trn_mispredict}, 32'd1);
      cyc(); idle_in(); i_trn_update = 1'b1; settle();
      check("t3_busy", {31'd0, o_busy}, 32'd1);
      cyc(); idle_in(); expect_op(OP_TWR, 8'h12, 1'b0); settle();
      cyc(); idle_in(); settle();
      check("t5_busy", {31'd0, o_busy}, 32'd0);

      // Starvation, then EVAL without write (GHR = 0x01 -> 0x02).
      cyc(); idle_in(); fb(32'h80, 7'h00, 1'b0, 1'b0); settle();
      cyc(); idle_in(); req(32'h0); expect_op(OP_PRED, 8'h02, 1'b0); settle();
      check("s1_ghr", {25'd0, o_req_hist}, 32'h02);
      for (int i = 0; i < 4; i++) begin
         cyc(); idle_in(); req(32'h0); expect_op(OP_PRED, 8'h02, 1'b0); settle();
         check("s_defer_stall", {31'd0, o_req_stall}, 32'd0);
      end
      cyc(); idle_in(); req(32'h0); expect_op(OP_TRD, 8'h20, 1'b1); settle();
      check("s6_req_stall", {31'd0, o_req_stall}, 32'd1);
      cyc(); idle_in(); req(32'h0); expect_op(OP_PRED, 8'h02, 1'b0); settle();
      check("s7_req_stall", {31'd0, o_req_stall}, 32'd0);
      check("s7_busy",      {31'd0, o_busy}, 32'd1);
      cyc(); idle_in(); req(32'h0); expect_op(OP_PRED, 8'h02, 1'b0); settle();
      check("s8_busy", {31'd0, o_busy}, 32'd0);

      // Full queue while predictions hold the port (GHR = 0x02).
      cyc(); idle_in(); fb(32'h100, 7'h05, 1'b1, 1'b0); settle();
      cyc(); idle_in(); req(32'h0); expect_op(OP_PRED, 8'h05, 1'b0); settle();
      check("p1_ghr", {25'd0, o_req_hist}, 32'h05);
      cyc(); idle_in(); req(32'h0); fb(32'h04, 7'h02, 1'b0, 1'b1);
      expect_op(OP_PRED, 8'h05, 1'b0); settle();
      check("p2_fb_stall", {31'd0, o_fb_stall}, 32'd0);
      cyc(); idle_in(); req(32'h0); fb(32'h08, 7'h00, 1'b0, 1'b0);
      expect_op(OP_PRED, 8'h0A, 1'b0); settle();
      cyc(); idle_in(); req(32'h0); fb(32'h0C, 7'h00, 1'b0, 1'b0);
      expect_op(OP_PRED, 8'h14, 1'b0); settle();
      cyc(); idle_in(); req(32'h0); fb(32'h10, 7'h00, 1'b0, 1'b0);
      expect_op(OP_PRED, 8'h28, 1'b0); settle();
      check("p5_fb_stall", {31'd0, o_fb_stall}, 32'd0);
      cyc(); idle_in(); req(32'h0); fb(32'h14, 7'h00, 1'b1, 1'b0);
      expect_op(OP_TRD, 8'h45, 1'b1); settle();
      check("p6_fb_stall_5th", {31'd0, o_fb_stall}, {31'd0, fs_full});
      cyc(); idle_in(); req(32'h0); expect_op(OP_PRED, {1'b0, g7}, 1'b0); settle();
      check("p7_ghr", {25'd0, o_req_hist}, {25'd0, g7});
`ifdef BP_SCHED_DROP_EN
      check("p7_drop_cnt", {16'd0, o_drop_cnt}, 32'd1);
`endif
      cyc(); idle_in(); req(32'h0); fb(32'h18, 7'h00, 1'b0, 1'b0);
      expect_op(OP_PRED, {1'b0, g7}, 1'b0); settle();
      check("p8_fb_stall_popcyc", {31'd0, o_fb_stall}, {31'd0, fs_full});
      cyc(); idle_in(); expect_op(OP_TRD, 8'h03, 1'b0); settle();
      check("p9_trn_mis",  {31'd0, o_trn_mispredict}, 32'd1);
      check("p9_fb_stall", {31'd0, o_fb_stall}, 32'd0);
      check("p9_ghr",      {25'd0, o_req_hist}, {25'd0, g9});
`ifdef BP_SCHED_DROP_EN
      check("p9_drop_cnt", {16'd0, o_drop_cnt}, 32'd2);
`endif
      cyc(); idle_in(); i_trn_update = 1'b1; settle();

      // Reset while in WR: queued entries and history are discarded.
      cyc(); idle_in(); expect_op(OP_TWR, 8'h03, 1'b0); rst_n = 1'b0; settle();
      cyc(); idle_in(); rst_n = 1'b1; settle();
      check("r_tbl_op",   {30'd0, o_tbl_op}, 32'd0);
      check("r_busy",     {31'd0, o_busy}, 32'd0);
      check("r_ghr",      {25'd0, o_req_hist}, 32'd0);
      check("r_trn",      {23'd0, o_trn_hist, o_trn_outcome, o_trn_mispredict}, 32'd0);
`ifdef BP_SCHED_DROP_EN
      check("r_drop_cnt", {16'd0, o_drop_cnt}, 32'd0);
`endif
      for (int i = 0; i < 6; i++) begin
         cyc(); idle_in(); settle();
         check("r_idle_busy", {31'd0, o_busy}, 32'd0);
      end

      @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
